// File: rtl/intercal_roman_readout.sv
// Converts a written value to an ASCII Roman-numeral string and queues it in a character FIFO
// for byte-wise draining. Define INTERCAL_ROMAN_NEWLINE_EN to terminate each string with LF.
module intercal_roman_readout #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_VALUE  = 3999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_NL, S_DONE} state_t;

    state_t      state_q;
    logic [11:0] rem_q;
    logic [3:0]  idx_q;
    logic        half_q, zero_q, busy_q, error_q, overrun_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] count_q;

    logic        wr_en, rd_en, wr_value, wr_clear, rd_char;
    logic [31:0] wr_data;
    logic [11:0] tok_val;
    logic [7:0]  tok_c0, tok_c1;
    logic        tok_two;
    logic        push_req, push_ok, stall, pop, fifo_full, fifo_empty;
    logic [7:0]  push_char, head;
    logic        unused_ui;

    assign uo_out     = 8'd0;
    assign data_ready = 1'b1;
    assign unused_ui  = ^ui_in;

    assign wr_en    = (data_write_n != 2'b11);
    assign rd_en    = (data_read_n != 2'b11);
    assign wr_value = wr_en && (address == 6'h00);
    assign wr_clear = wr_en && (address == 6'h08);
    assign rd_char  = rd_en && (address == 6'h04);

    always_comb begin
        case (data_write_n)
            2'b00:   wr_data = {24'd0, data_in[7:0]};
            2'b01:   wr_data = {16'd0, data_in[15:0]};
            default: wr_data = data_in;
        endcase
    end

    // Subtractive-notation token table, largest first; two-char tokens emit c0 then c1.
    always_comb begin
        tok_c1  = 8'h00;
        tok_two = 1'b0;
        case (idx_q)
            4'd0:    begin tok_val = 12'd1000; tok_c0 = 8'h4D; end
            4'd1:    begin tok_val = 12'd900;  tok_c0 = 8'h43; tok_c1 = 8'h4D; tok_two = 1'b1; end
            4'd2:    begin tok_val = 12'd500;  tok_c0 = 8'h44; end
            4'd3:    begin tok_val = 12'd400;  tok_c0 = 8'h43; tok_c1 = 8'h44; tok_two = 1'b1; end
            4'd4:    begin tok_val = 12'd100;  tok_c0 = 8'h43; end
            4'd5:    begin tok_val = 12'd90;   tok_c0 = 8'h58; tok_c1 = 8'h43; tok_two = 1'b1; end
            4'd6:    begin tok_val = 12'd50;   tok_c0 = 8'h4C; end
            4'd7:    begin tok_val = 12'd40;   tok_c0 = 8'h58; tok_c1 = 8'h4C; tok_two = 1'b1; end
            4'd8:    begin tok_val = 12'd10;   tok_c0 = 8'h58; end
            4'd9:    begin tok_val = 12'd9;    tok_c0 = 8'h49; tok_c1 = 8'h58; tok_two = 1'b1; end
            4'd10:   begin tok_val = 12'd5;    tok_c0 = 8'h56; end
            4'd11:   begin tok_val = 12'd4;    tok_c0 = 8'h49; tok_c1 = 8'h56; tok_two = 1'b1; end
            default: begin tok_val = 12'd1;    tok_c0 = 8'h49; end
        endcase
    end

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    always_comb begin
        push_req  = 1'b0;
        push_char = 8'h00;
        case (state_q)
            S_CONV: begin
                if (rem_q == 12'd0 && !half_q) begin
                    push_req  = zero_q;
                    push_char = 8'h5F;
                end else if (half_q) begin
                    push_req  = 1'b1;
                    push_char = tok_c1;
                end else if (rem_q >= tok_val) begin
                    push_req  = 1'b1;
                    push_char = tok_c0;
                end
            end
            S_NL: begin
                push_req  = 1'b1;
                push_char = 8'h0A;
            end
            default: ;
        endcase
    end

    assign stall   = push_req && fifo_full;
    assign push_ok = push_req && !fifo_full && !wr_clear;
    assign pop     = rd_char && !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rem_q     <= 12'd0;
            idx_q     <= 4'd0;
            half_q    <= 1'b0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (wr_clear) begin
            state_q   <= S_IDLE;
            half_q    <= 1'b0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                S_CONV: if (!stall) begin
                    if (rem_q == 12'd0 && !half_q) begin
                        zero_q <= 1'b0;
`ifdef INTERCAL_ROMAN_NEWLINE_EN
                        state_q <= S_NL;
`else
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
`endif
                    end else if (half_q) begin
                        half_q <= 1'b0;
                        rem_q  <= rem_q - tok_val;
                    end else if (rem_q < tok_val) begin
                        idx_q <= idx_q + 4'd1;
                    end else if (tok_two) begin
                        half_q <= 1'b1;
                    end else begin
                        rem_q <= rem_q - tok_val;
                    end
                end
                S_NL: if (!stall) begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                end
                S_DONE:  state_q <= S_IDLE;
                default: ;
            endcase
            // A write accepted in DONE overrides the return to IDLE above.
            if (wr_value) begin
                if (busy_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    rem_q     <= wr_data[11:0];
                    idx_q     <= 4'd0;
                    half_q    <= 1'b0;
                    zero_q    <= (wr_data == 32'd0);
                    overrun_q <= 1'b0;
                    if (wr_data > 32'(MAX_VALUE)) begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        error_q <= 1'b0;
                        state_q <= S_CONV;
                        busy_q  <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else if (wr_clear) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wp_q <= wp_q + AW'(1);
            if (pop)     rp_q <= rp_q + AW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wp_q] <= push_char;
    end

    assign head = fifo_empty ? 8'h00 : mem_q[rp_q];

    always_comb begin
        data_out = 32'd0;
        if (rd_en) begin
            case (address)
                6'h00: data_out = {16'd0, 8'(count_q), 3'd0, fifo_full, fifo_empty,
                                   overrun_q, error_q, busy_q};
                6'h04: data_out = {24'd0, head};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_intercal_roman_readout.sv
// Randomised self-checking bench for intercal_roman_readout against a greedy Roman-numeral model.
module tb_intercal_roman_readout;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ui_in, uo_out;
    logic [5:0]  address;
    logic [31:0] data_in, data_out;
    logic [1:0]  data_write_n, data_read_n;
    logic        data_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int unsigned tv[13] = '{1000, 900, 500, 400, 100, 90, 50, 40, 10, 9, 5, 4, 1};
    string       ts[13] = '{"M", "CM", "D", "CD", "C", "XC", "L", "XL", "X", "IX", "V", "IV", "I"};

    intercal_roman_readout #(.FIFO_DEPTH(DEPTH), .MAX_VALUE(3999)) dut (
        .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out), .address(address),
        .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready)
    );

    always #5 clk = ~clk;

    // Reference: greedy decomposition of the value into the standard Roman tokens.
    task automatic build_exp(input longint unsigned v);
        exp_q.delete();
        if (v > 3999) return;
        if (v == 0) exp_q.push_back(8'h5F);
        for (int i = 0; i < 13; i++) begin
            while (v >= tv[i]) begin
                for (int k = 0; k < ts[i].len(); k++) exp_q.push_back(ts[i][k]);
                v -= tv[i];
            end
        end
`ifdef INTERCAL_ROMAN_NEWLINE_EN
        exp_q.push_back(8'h0A);
`endif
    endtask

    function automatic logic [31:0] status_word(bit busy, bit err, bit ov, int cnt);
        return {16'd0, 8'(cnt), 3'd0, (cnt == DEPTH), (cnt == 0), ov, err, busy};
    endfunction

    function automatic int first_diff();
        int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
        return (got_q.size() == exp_q.size()) ? -1 : n;
    endfunction

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
        @(negedge clk);
        address = a; data_in = d; data_write_n = wn;
        @(posedge clk);
        #1 data_write_n = 2'b11;
    endtask

    task automatic bus_read(input logic [5:0] a, input logic [1:0] rn, output logic [31:0] d);
        @(negedge clk);
        address = a; data_read_n = rn;
        #1 d = data_out;
        @(posedge clk);
        #1 data_read_n = 2'b11;
    endtask

    task automatic wait_not_busy(input int budget, output int cycles, output logic [31:0] st);
        cycles = 0;
        st = 32'h1;
        while (st[0] && cycles < budget) begin
            bus_read(6'h00, 2'b10, st);
            cycles++;
        end
        n_checks++;
        if (st[0]) begin
            n_fail++;
            $display("FAIL busy_timeout: busy still %0d after %0d reads, required 0", st[0], cycles);
        end
    endtask

    // Pops until the FIFO is empty and the converter is idle, with random gaps and widths.
    task automatic drain(input int budget);
        logic [31:0] d;
        bit done = 0;
        got_q.delete();
        for (int i = 0; i < budget && !done; i++) begin
            if ($urandom_range(0, 3) == 0) @(posedge clk);
            bus_read(6'h04, 2'($urandom_range(0, 2)), d);
            if (d != 0) got_q.push_back(d[7:0]);
            else begin
                bus_read(6'h00, 2'b10, d);
                if (!d[0] && d[3]) done = 1;
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain_timeout: drained %0d chars, fifo not empty/idle within %0d reads", got_q.size(), budget);
        end
    endtask

    task automatic check_string(input string name);
        int dpos = first_diff();
        n_checks++;
        if (dpos >= 0) begin
            n_fail++;
            $display("FAIL %s: got %0d chars, required %0d; at %0d got %h required %h", name,
                     got_q.size(), exp_q.size(), dpos,
                     (dpos < got_q.size()) ? got_q[dpos] : 8'h00,
                     (dpos < exp_q.size()) ? exp_q[dpos] : 8'h00);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bus_read(6'h00, 2'b10, d);
        n_checks++;
        if (d !== status_word(0, 0, 0, 0)) begin n_fail++; $display("FAIL reset_status: got %h required %h", d, status_word(0, 0, 0, 0)); end
        bus_read(6'h04, 2'b00, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_char: got %h required 0", d); end
        bus_read(6'h10, 2'b10, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL other_offset: got %h required 0", d); end
        n_checks++;
        if (uo_out !== 8'd0 || data_ready !== 1'b1) begin
            n_fail++; $display("FAIL tie_offs: uo_out %h data_ready %b required 00 1", uo_out, data_ready);
        end
    endtask

    task automatic test_1994();
        logic [31:0] d;
        int cyc, n;
        build_exp(1994);
        n = exp_q.size();
        bus_write(6'h00, 32'd1994, 2'b10);
        wait_not_busy(40, cyc, d);
        for (int i = 0; i < n; i++) begin
            bus_read(6'h00, 2'b10, d);
            n_checks++;
            if (d !== status_word(0, 0, 0, n - i)) begin n_fail++; $display("FAIL count_step_%0d: got %h required %h", i, d, status_word(0, 0, 0, n - i)); end
            bus_read(6'h04, 2'b00, d);
            n_checks++;
            if (d !== {24'd0, exp_q[i]}) begin n_fail++; $display("FAIL char_1994_%0d: got %h required %h", i, d, exp_q[i]); end
        end
        bus_read(6'h04, 2'b01, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL empty_pop: got %h required 0", d); end
        bus_read(6'h00, 2'b10, d);
        n_checks++;
        if (d !== status_word(0, 0, 0, 0)) begin n_fail++; $display("FAIL after_drain: got %h required %h", d, status_word(0, 0, 0, 0)); end
    endtask

    task automatic test_3888();
        logic [31:0] d;
        int cyc;
        build_exp(3888);
        bus_write(6'h00, 32'd3888, 2'b01);
        wait_not_busy(40, cyc, d);
        n_checks++;
        if (cyc > 32) begin n_fail++; $display("FAIL busy_latency: busy cleared after %0d cycles, required <= 32", cyc); end
        n_checks++;
        if (d !== status_word(0, 0, 0, exp_q.size())) begin n_fail++; $display("FAIL status_3888: got %h required %h", d, status_word(0, 0, 0, exp_q.size())); end
        drain(60);
        check_string("str_3888");
    endtask

    task automatic test_zero_and_errors();
        logic [31:0] d;
        int cyc;
        build_exp(0);
        bus_write(6'h00, 32'd0, 2'b00);
        drain(20);
        check_string("str_zero");
        bus_write(6'h00, 32'd4000, 2'b10);
        bus_read(6'h00, 2'b10, d);
        n_checks++;
        if (d !== status_word(0, 1, 0, 0)) begin n_fail++; $display("FAIL err_4000: got %h required %h", d, status_word(0, 1, 0, 0)); end
        bus_write(6'h00, 32'h0001_0001, 2'b10);
        bus_read(6'h00, 2'b10, d);
        n_checks++;
        if (d !== status_word(0, 1, 0, 0)) begin n_fail++; $display("FAIL err_wide: got %h required %h", d, status_word(0, 1, 0, 0)); end
        build_exp(1);
        bus_write(6'h00, 32'h0001_0001, 2'b01);
        wait_not_busy(40, cyc, d);
        n_checks++;
        if (d[1] !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b required 0", d[1]); end
        drain(20);
        check_string("str_16bit_trunc");
        build_exp(3999);
        bus_write(6'h00, 32'd3999, 2'b10);
        drain(60);
        check_string("str_3999");
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        int cyc;
        build_exp(3888);
        bus_write(6'h00, 32'd3888, 2'b10);
        bus_write(6'h00, 32'd3888, 2'b10);
        wait_not_busy(40, cyc, d);
        n_checks++;
        if (d !== status_word(0, 0, 1, exp_q.size())) begin n_fail++; $display("FAIL overrun_set: got %h required %h", d, status_word(0, 0, 1, exp_q.size())); end
        drain(60);
        check_string("str_overrun");
        build_exp(5);
        bus_write(6'h00, 32'd5, 2'b00);
        wait_not_busy(40, cyc, d);
        n_checks++;
        if (d !== status_word(0, 0, 0, exp_q.size())) begin n_fail++; $display("FAIL overrun_clr: got %h required %h", d, status_word(0, 0, 0, exp_q.size())); end
        drain(20);
        check_string("str_5");
    endtask

    task automatic test_stall();
        logic [31:0] d;
        logic [7:0]  tail_q[$];
        int cyc, skip;
        build_exp(3888);
        skip = exp_q.size() - 14;
        bus_write(6'h00, 32'd3888, 2'b10);
        wait_not_busy(40, cyc, d);
        for (int i = 0; i < skip; i++) bus_read(6'h04, 2'b00, d);
        tail_q = exp_q[skip:$];
        bus_read(6'h00, 2'b10, d);
        n_checks++;
        if (d !== status_word(0, 0, 0, 14)) begin n_fail++; $display("FAIL prefill: got %h required %h", d, status_word(0, 0, 0, 14)); end
        build_exp(1994);
        exp_q = {tail_q, exp_q};
        bus_write(6'h00, 32'd1994, 2'b10);
        repeat (40) @(posedge clk);
        bus_read(6'h00, 2'b10, d);
        n_checks++;
        if (d !== status_word(1, 0, 0, DEPTH)) begin n_fail++; $display("FAIL stalled: got %h required %h", d, status_word(1, 0, 0, DEPTH)); end
        drain(100);
        check_string("str_stall");
    endtask

    task automatic test_clear();
        logic [31:0] d;
        bus_write(6'h00, 32'd3888, 2'b10);
        repeat (6) @(posedge clk);
        bus_write(6'h08, 32'd0, 2'b00);
        bus_read(6'h00, 2'b10, d);
        n_checks++;
        if (d !== status_word(0, 0, 0, 0)) begin n_fail++; $display("FAIL clear_conv: got %h required %h", d, status_word(0, 0, 0, 0)); end
        bus_write(6'h00, 32'd5000, 2'b10);
        bus_write(6'h08, 32'd0, 2'b10);
        bus_read(6'h00, 2'b10, d);
        n_checks++;
        if (d !== status_word(0, 0, 0, 0)) begin n_fail++; $display("FAIL clear_err: got %h required %h", d, status_word(0, 0, 0, 0)); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0]  first;
        build_exp(3888);
        bus_write(6'h00, 32'd3888, 2'b10);
        @(negedge clk);
        bus_read(6'h04, 2'b00, d);
        first = d[7:0];
        n_checks++;
        if (d !== {24'd0, exp_q[0]}) begin n_fail++; $display("FAIL pushpop_head: got %h required %h", d, exp_q[0]); end
        bus_read(6'h00, 2'b10, d);
        n_checks++;
        if (d !== status_word(1, 0, 0, 1)) begin n_fail++; $display("FAIL pushpop_count: got %h required %h", d, status_word(1, 0, 0, 1)); end
        drain(60);
        got_q.push_front(first);
        check_string("str_pushpop");
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        bus_write(6'h00, 32'd3888, 2'b10);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        address = 6'h00; data_read_n = 2'b10;
        #1 d = data_out;
        data_read_n = 2'b11;
        n_checks++;
        if (d !== status_word(0, 0, 0, 0)) begin n_fail++; $display("FAIL async_rst: got %h required %h", d, status_word(0, 0, 0, 0)); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        build_exp(7);
        bus_write(6'h00, 32'd7, 2'b10);
        drain(20);
        check_string("str_after_rst");
    endtask

    task automatic test_random();
        logic [31:0] d, data;
        longint unsigned v;
        logic [1:0] wn;
        int cyc;
        for (int it = 0; it < 40; it++) begin
            wn = 2'($urandom_range(0, 2));
            case (wn)
                2'b00: begin v = $urandom_range(0, 255); data = ($urandom() & 32'hFFFF_FF00) | 32'(v); end
                2'b01: begin
                    v = ($urandom_range(0, 7) == 0) ? $urandom_range(4000, 65535) : $urandom_range(0, 4000);
                    data = ($urandom() & 32'hFFFF_0000) | 32'(v);
                end
                default: begin
                    v = ($urandom_range(0, 7) == 0) ? longint'($urandom()) : $urandom_range(0, 4100);
                    data = 32'(v);
                end
            endcase
            build_exp(v);
            bus_write(6'h00, data, wn);
            drain(80);
            check_string($sformatf("rnd_str_%0d_v%0d", it, v));
            bus_read(6'h00, 2'b10, d);
            n_checks++;
            if (d !== status_word(0, (v > 3999), 0, 0)) begin
                n_fail++; $display("FAIL rnd_status_%0d v=%0d: got %h required %h", it, v, d, status_word(0, (v > 3999), 0, 0));
            end
        end
        wait_not_busy(5, cyc, d);
    endtask

    initial begin
        rst = 1'b1;
        ui_in = 8'd0; address = 6'd0; data_in = 32'd0;
        data_write_n = 2'b11; data_read_n = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_1994();
        test_3888();
        test_zero_and_errors();
        test_overrun();
        test_stall();
        test_clear();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
